// File: rtl/regfile_wb_ctrl_if.sv
// Bundles the write-back controller's ALU, load, reservation and register-bank signals.
// Naming is from the controller's side: the issue/execute stages drive the master side.
interface regfile_wb_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic                 alu_valid;
  logic                 alu_ready;
  logic [ADDR_W-1:0]    alu_ws;
  logic [DATA_W-1:0]    alu_wd;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [ADDR_W-1:0]    ld_ws;
  logic [DATA_W-1:0]    ld_wd;
  logic                 rsv_valid;
  logic [ADDR_W-1:0]    rsv_ws;
  logic [2**ADDR_W-1:0] busy;
  logic                 rsv_err;
  logic                 wvalid;
  logic [ADDR_W-1:0]    ws;
  logic [DATA_W-1:0]    wd;

  modport master (
    output alu_valid, alu_ws, alu_wd, ld_valid, ld_ws, ld_wd, rsv_valid, rsv_ws,
    input  alu_ready, ld_ready, busy, rsv_err, wvalid, ws, wd
  );

  modport slave (
    input  alu_valid, alu_ws, alu_wd, ld_valid, ld_ws, ld_wd, rsv_valid, rsv_ws,
    output alu_ready, ld_ready, busy, rsv_err, wvalid, ws, wd
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the register bank: merges ALU results and FIFO-buffered load
// results onto one write port per cycle and tracks reserved destinations in a busy scoreboard.
module regfile_wb_ctrl #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int NREG  = 2**ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] ws;
    logic [DATA_W-1:0] wd;
  } entry_t;

  entry_t            fifo_mem_q [FIFO_DEPTH];
  entry_t            fifo_mem_d [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              wvalid_q, wvalid_d;
  logic [ADDR_W-1:0] ws_q, ws_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              rsv_err_q, rsv_err_d;

  logic   fifo_full;
  logic   fifo_empty;
  logic   push;
  logic   pop;
  entry_t head;

  // Wrap-bit pointers: equal low bits with differing wrap bit means every slot is occupied.
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

  assign bus.alu_ready = !fifo_full;
  assign bus.ld_ready  = !fifo_full;
  assign bus.wvalid    = wvalid_q;
  assign bus.ws        = ws_q;
  assign bus.wd        = wd_q;
  assign bus.busy      = busy_q;
  assign bus.rsv_err   = rsv_err_q;

  // A full FIFO outranks the ALU so loads can never be starved once the buffer backs up.
  always_comb begin
    push       = bus.ld_valid && !fifo_full;
    pop        = 1'b0;
    wvalid_d   = 1'b0;
    ws_d       = ws_q;
    wd_d       = wd_q;
    fifo_mem_d = fifo_mem_q;

    if (fifo_full) begin
      pop      = 1'b1;
      wvalid_d = 1'b1;
      ws_d     = head.ws;
      wd_d     = head.wd;
    end else if (bus.alu_valid) begin
      wvalid_d = 1'b1;
      ws_d     = bus.alu_ws;
      wd_d     = bus.alu_wd;
    end else if (!fifo_empty) begin
      pop      = 1'b1;
      wvalid_d = 1'b1;
      ws_d     = head.ws;
      wd_d     = head.wd;
    end

    if (push) begin
      fifo_mem_d[wr_ptr_q[PTR_W-1:0]] = '{ws: bus.ld_ws, wd: bus.ld_wd};
    end
    wr_ptr_d = push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;
  end

  // Clear on the edge the bank writes, then apply the reservation so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (wvalid_q) begin
      busy_d[ws_q] = 1'b0;
    end
    if (bus.rsv_valid) begin
      busy_d[bus.rsv_ws] = 1'b1;
    end
    rsv_err_d = bus.rsv_valid && busy_q[bus.rsv_ws] &&
                !(wvalid_q && (ws_q == bus.rsv_ws));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem_q <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wvalid_q   <= 1'b0;
      ws_q       <= '0;
      wd_q       <= '0;
      busy_q     <= '0;
      rsv_err_q  <= 1'b0;
    end else begin
      fifo_mem_q <= fifo_mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wvalid_q   <= wvalid_d;
      ws_q       <= ws_d;
      wd_q       <= wd_d;
      busy_q     <= busy_d;
      rsv_err_q  <= rsv_err_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: reset, ALU path, arbitration, back-pressure,
// scoreboard hazards and mid-operation reset, with hand-computed expectations.
module tb_regfile_wb_ctrl;
  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  regfile_wb_ctrl_if #(.DATA_W(16), .ADDR_W(4)) bus_if ();

  regfile_wb_ctrl #(.DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic av, input logic [3:0] aws, input logic [15:0] awd,
                               input logic lv, input logic [3:0] lws, input logic [15:0] lwd,
                               input logic rv, input logic [3:0] rws);
    bus_if.alu_valid = av;
    bus_if.alu_ws    = aws;
    bus_if.alu_wd    = awd;
    bus_if.ld_valid  = lv;
    bus_if.ld_ws     = lws;
    bus_if.ld_wd     = lwd;
    bus_if.rsv_valid = rv;
    bus_if.rsv_ws    = rws;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
  endtask

  task automatic checkWrite(input string tag, input logic v, input logic [3:0] s, input logic [15:0] d);
    checkOutput({tag, ".wvalid"}, 32'(bus_if.wvalid), 32'(v));
    checkOutput({tag, ".ws"}, 32'(bus_if.ws), 32'(s));
    checkOutput({tag, ".wd"}, 32'(bus_if.wd), 32'(d));
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    idle();

    // Reset held two cycles
    tick();
    tick();
    checkWrite("reset", 1'b0, 4'd0, 16'h0);
    checkOutput("reset.busy", 32'(bus_if.busy), 32'h0);
    checkOutput("reset.rsv_err", 32'(bus_if.rsv_err), 32'h0);
    checkOutput("reset.alu_ready", 32'(bus_if.alu_ready), 32'h1);
    checkOutput("reset.ld_ready", 32'(bus_if.ld_ready), 32'h1);
    rst = 1'b0;
    tick();

    // ALU path with reservation of r3
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd3);
    tick();
    checkOutput("alu.busy_c1", 32'(bus_if.busy), 32'h0008);
    applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    tick();
    checkWrite("alu.c2", 1'b1, 4'd3, 16'hBEEF);
    checkOutput("alu.busy_c2", 32'(bus_if.busy), 32'h0008);
    idle();
    tick();
    checkWrite("alu.c3", 1'b0, 4'd3, 16'hBEEF);
    checkOutput("alu.busy_c3", 32'(bus_if.busy), 32'h0000);

    // ALU and load together: ALU first, load one cycle later
    applyStimulus(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0, 4'd0);
    tick();
    checkWrite("arb.c1", 1'b1, 4'd1, 16'h1111);
    idle();
    tick();
    checkWrite("arb.c2", 1'b1, 4'd2, 16'h2222);
    tick();
    checkOutput("arb.c3.wvalid", 32'(bus_if.wvalid), 32'h0);
    checkOutput("arb.busy", 32'(bus_if.busy), 32'h0);

    // Back-pressure: ALU hogs the port while four loads fill the FIFO
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("bp.ld_ready%0d", k), 32'(bus_if.ld_ready), 32'h1);
      applyStimulus(1'b1, 4'd10, 16'hAAAA, 1'b1, 4'(12 + k), 16'hD000 + 16'(k), 1'b0, 4'd0);
      tick();
      checkWrite($sformatf("bp.alu%0d", k), 1'b1, 4'd10, 16'hAAAA);
    end
    checkOutput("bp.full.ld_ready", 32'(bus_if.ld_ready), 32'h0);
    checkOutput("bp.full.alu_ready", 32'(bus_if.alu_ready), 32'h0);
    applyStimulus(1'b1, 4'd10, 16'hAAAA, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    tick();
    checkWrite("bp.pop0", 1'b1, 4'd12, 16'hD000);
    checkOutput("bp.drain.ld_ready", 32'(bus_if.ld_ready), 32'h1);
    tick();
    checkWrite("bp.alu_after", 1'b1, 4'd10, 16'hAAAA);
    idle();
    for (int k = 1; k < 4; k++) begin
      tick();
      checkWrite($sformatf("bp.pop%0d", k), 1'b1, 4'(12 + k), 16'hD000 + 16'(k));
    end
    tick();
    checkOutput("bp.done.wvalid", 32'(bus_if.wvalid), 32'h0);

    // Double reservation of r5 flags an error for one cycle
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd5);
    tick();
    checkOutput("hz5.busy1", 32'(bus_if.busy), 32'h0020);
    checkOutput("hz5.err0", 32'(bus_if.rsv_err), 32'h0);
    tick();
    checkOutput("hz5.err1", 32'(bus_if.rsv_err), 32'h1);
    checkOutput("hz5.busy2", 32'(bus_if.busy), 32'h0020);
    applyStimulus(1'b1, 4'd5, 16'h5555, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    tick();
    checkOutput("hz5.err_pulse", 32'(bus_if.rsv_err), 32'h0);
    idle();
    tick();
    checkOutput("hz5.cleared", 32'(bus_if.busy), 32'h0);

    // Re-reserving r7 on the edge its write lands keeps it busy without error
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7);
    tick();
    applyStimulus(1'b1, 4'd7, 16'h7777, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    tick();
    checkWrite("hz7.write", 1'b1, 4'd7, 16'h7777);
    applyStimulus(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7);
    tick();
    checkOutput("hz7.busy_kept", 32'(bus_if.busy), 32'h0080);
    checkOutput("hz7.no_err", 32'(bus_if.rsv_err), 32'h0);
    applyStimulus(1'b1, 4'd7, 16'h7070, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
    tick();
    idle();
    tick();
    checkOutput("hz7.cleared", 32'(bus_if.busy), 32'h0);

    // Mid-operation reset with three loads buffered behind the ALU
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 4'd10, 16'hA0A0, 1'b1, 4'(13 + k), 16'hE000 + 16'(k), k == 0, 4'd9);
      tick();
    end
    checkOutput("mid.busy_pre", 32'(bus_if.busy), 32'h0200);
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkWrite("mid.rst", 1'b0, 4'd0, 16'h0);
    checkOutput("mid.busy", 32'(bus_if.busy), 32'h0);
    checkOutput("mid.ld_ready", 32'(bus_if.ld_ready), 32'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkWrite($sformatf("mid.after%0d", k), 1'b0, 4'd0, 16'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
